// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S sample feeder and its FIFO.
package i2s_pkg;

    localparam int SAMPLE_W  = 16;
    localparam int FRAME_LEN = 16;
    localparam int CNT_W     = $clog2(FRAME_LEN);

    localparam logic WS_LEFT  = 1'b0;
    localparam logic WS_RIGHT = 1'b1;

    // Counter value on which the next word is loaded into the output register.
    localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(FRAME_LEN - 1);

    typedef logic [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO with occupancy count; push into full and pop from
// empty are ignored so the level can never leave 0..DEPTH.
module sample_fifo
    import i2s_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  sample_t          push_data,
    input  logic             pop,
    output sample_t          head,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);

    sample_t          mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign full  = (level_q == LVL_W'(DEPTH));
    assign empty = (level_q == LVL_W'(0));
    assign level = level_q;
    assign head  = mem_q[rd_ptr_q];

    // Qualify requests and compute next pointers and occupancy.
    always_comb begin
        do_push_s = push && !full;
        do_pop_s  = pop && !empty;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (do_push_s && !do_pop_s) begin
            level_d = level_q + LVL_W'(1);
        end else if (do_pop_s && !do_push_s) begin
            level_d = level_q - LVL_W'(1);
        end else begin
            level_d = level_q;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Sample storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/i2s_sample_feeder.sv
// Feeds one held sample word per 16-clock frame to the serial shifter,
// alternating left/right and substituting silence when the FIFO runs dry.
module i2s_sample_feeder
    import i2s_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = SAMPLE_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [WIDTH-1:0]           data,
    output logic                       word_start,
    output logic                       ws,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       underrun,
    input  logic                       clr_underrun
);

    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    sample_t          data_q, data_d;
    logic             ws_q, ws_d;
    logic             word_start_q, word_start_d;
    logic             underrun_q, underrun_d;

    logic             load_s;
    logic             push_s;
    logic             pop_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    sample_t          fifo_head_s;

    assign load_s   = (bit_cnt_q == LOAD_CNT);
    assign in_ready = !fifo_full_s;
    assign push_s   = in_valid && in_ready;
    assign pop_s    = load_s && !fifo_empty_s;

    sample_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (in_data),
        .pop       (pop_s),
        .head      (fifo_head_s),
        .level     (level),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // Frame counter, word load, channel toggle and sticky underrun.
    always_comb begin
        bit_cnt_d    = bit_cnt_q + CNT_W'(1);
        data_d       = data_q;
        ws_d         = ws_q;
        word_start_d = 1'b0;
        underrun_d   = underrun_q;
        if (load_s) begin
            if (!fifo_empty_s) begin
                data_d = fifo_head_s;
            end else begin
                data_d = '0;
            end
            ws_d         = ~ws_q;
            word_start_d = 1'b1;
        end else begin
            data_d       = data_q;
            ws_d         = ws_q;
            word_start_d = 1'b0;
        end
        // A fresh underrun outranks a clear on the same edge.
        if (load_s && fifo_empty_s) begin
            underrun_d = 1'b1;
        end else if (clr_underrun) begin
            underrun_d = 1'b0;
        end else begin
            underrun_d = underrun_q;
        end
    end

    // Output and frame-state registers; ws starts right so the first word is left.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_q    <= '0;
            data_q       <= '0;
            ws_q         <= WS_RIGHT;
            word_start_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            bit_cnt_q    <= bit_cnt_d;
            data_q       <= data_d;
            ws_q         <= ws_d;
            word_start_q <= word_start_d;
            underrun_q   <= underrun_d;
        end
    end

    assign data       = data_q;
    assign ws         = ws_q;
    assign word_start = word_start_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_i2s_sample_feeder.sv
// Scoreboard bench for i2s_sample_feeder: a reference queue model predicts
// every presented word, a negedge monitor compares, directed phases add
// hand-computed checks for timing, full, collisions and reset.
module tb_i2s_sample_feeder;

    localparam int DEPTH = 8;
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [15:0]      in_data = 16'h0000;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [15:0]      data;
    logic             word_start;
    logic             ws;
    logic [LVL_W-1:0] level;
    logic             underrun;
    logic             clr_underrun = 1'b0;

    i2s_sample_feeder #(.DEPTH(DEPTH), .WIDTH(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .data         (data),
        .word_start   (word_start),
        .ws           (ws),
        .level        (level),
        .underrun     (underrun),
        .clr_underrun (clr_underrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] mq[$];
    logic [16:0] exp_q[$];
    logic [3:0]  m_cnt = 4'd0;
    logic        m_ws = 1'b1;
    logic        m_strobe = 1'b0;
    logic        m_und = 1'b0;
    logic [15:0] m_data = 16'h0000;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mq.delete();
                exp_q.delete();
                m_cnt = 4'd0;
                m_ws = 1'b1;
                m_strobe = 1'b0;
                m_und = 1'b0;
                m_data = 16'h0000;
            end else begin
                int  sz;
                logic ld;
                sz = mq.size();
                ld = (m_cnt == 4'd15);
                if (ld) begin
                    if (sz > 0) m_data = mq.pop_front();
                    else        m_data = 16'h0000;
                    m_ws = ~m_ws;
                    m_strobe = 1'b1;
                    exp_q.push_back({m_ws, m_data});
                end else begin
                    m_strobe = 1'b0;
                end
                if (ld && sz == 0) m_und = 1'b1;
                else if (clr_underrun) m_und = 1'b0;
                if (in_valid && sz != DEPTH) mq.push_back(in_data);
                m_cnt = m_cnt + 4'd1;
            end
        end
    end

    // ---------------- monitor + shifter model ----------------
    logic [15:0] sh = 16'h0000;
    logic [15:0] asm_w = 16'h0000;
    int          sh_cnt = 0;
    logic        sh_rec = 1'b0;
    logic        rec_en = 1'b0;
    logic [15:0] rec_q[$];

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("level", 32'(level), 32'(mq.size()));
                check("in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
                check("underrun", 32'(underrun), 32'(m_und));
                check("data_hold", 32'(data), 32'(m_data));
                check("word_start", 32'(word_start), 32'(m_strobe));
                check("ws", 32'(ws), 32'(m_ws));
                if (word_start) begin
                    if (exp_q.size() == 0) begin
                        check("sb_unexpected_word", 32'(1), 32'(0));
                    end else begin
                        logic [16:0] e;
                        e = exp_q.pop_front();
                        check("sb_data", 32'(data), 32'(e[15:0]));
                        check("sb_ws", 32'(ws), 32'(e[16]));
                    end
                    sh = data;
                    sh_cnt = 0;
                    sh_rec = rec_en;
                end
                asm_w = {asm_w[14:0], sh[15]};
                sh = {sh[14:0], 1'b0};
                sh_cnt++;
                if (sh_cnt == 16 && sh_rec) rec_q.push_back(asm_w);
            end
        end
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic push(input logic [15:0] d);
        int  g;
        logic acc;
        g = 0;
        in_valid = 1'b1;
        in_data = d;
        forever begin
            acc = in_ready;
            @(negedge clk);
            g++;
            if (acc) break;
            if (g > 64) begin
                check("push_timeout", 32'(0), 32'(1));
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_ws();
        int g;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!word_start && g < 40);
        if (!word_start) check("wait_word_start_timeout", 32'(0), 32'(1));
    endtask

    task automatic wait_cnt(input logic [3:0] c);
        int g;
        g = 0;
        while (m_cnt != c && g < 40) begin
            @(negedge clk);
            g++;
        end
    endtask

    logic [15:0] sent_q[$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset behaviour: no pushes for 40 cycles.
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            check("rst_strobe", 32'(word_start), 32'(cyc == 16 || cyc == 32));
            check("rst_level", 32'(level), 32'(0));
            check("rst_data", 32'(data), 32'(0));
            if (cyc == 16) check("rst_ws_first", 32'(ws), 32'(0));
            if (cyc == 32) check("rst_ws_second", 32'(ws), 32'(1));
            check("rst_underrun", 32'(underrun), 32'(cyc >= 16));
        end

        // Basic ordering (load at cycle 48 is an underrun, then clear).
        wait_ws();
        clr_underrun = 1'b1;
        push(16'hA5A5);
        clr_underrun = 1'b0;
        push(16'h5A5A);
        check("ord_level2", 32'(level), 32'(2));
        check("ord_und0", 32'(underrun), 32'(0));
        wait_ws();
        check("ord_word1", 32'(data), 32'(16'hA5A5));
        check("ord_ws1", 32'(ws), 32'(1));
        check("ord_level1", 32'(level), 32'(1));
        wait_ws();
        check("ord_word2", 32'(data), 32'(16'h5A5A));
        check("ord_ws2", 32'(ws), 32'(0));
        check("ord_level0", 32'(level), 32'(0));
        check("ord_und_still0", 32'(underrun), 32'(0));

        // Full condition: 1..8 fill the FIFO, 9 waits for the next pop.
        for (int i = 1; i <= 8; i++) push(16'(i));
        check("full_ready_low", 32'(in_ready), 32'(0));
        check("full_level8", 32'(level), 32'(8));
        fork
            push(16'd9);
        join_none
        wait_ws();
        check("full_word1", 32'(data), 32'(1));
        @(negedge clk);
        check("full_level_after9", 32'(level), 32'(8));
        for (int i = 2; i <= 9; i++) begin
            wait_ws();
            check("full_word", 32'(data), 32'(i));
        end

        // Push on the load edge with level 3.
        push(16'h1111);
        push(16'h2222);
        push(16'h3333);
        check("sim_level3", 32'(level), 32'(3));
        wait_cnt(4'd15);
        push(16'h4444);
        check("sim_strobe", 32'(word_start), 32'(1));
        check("sim_level_kept", 32'(level), 32'(3));
        check("sim_oldest", 32'(data), 32'(16'h1111));
        wait_ws(); check("sim_w2", 32'(data), 32'(16'h2222));
        wait_ws(); check("sim_w3", 32'(data), 32'(16'h3333));
        wait_ws(); check("sim_w4", 32'(data), 32'(16'h4444));
        wait_ws();
        check("und_silence", 32'(data), 32'(0));
        check("und_set", 32'(underrun), 32'(1));

        // Clear colliding with a fresh underrun: set wins.
        wait_cnt(4'd15);
        clr_underrun = 1'b1;
        @(negedge clk);
        clr_underrun = 1'b0;
        check("und_set_wins", 32'(underrun), 32'(1));
        clr_underrun = 1'b1;
        @(negedge clk);
        clr_underrun = 1'b0;
        check("und_cleared", 32'(underrun), 32'(0));

        // Reset mid-frame with level 5 and bit_cnt 7.
        wait_ws();
        for (int i = 0; i < 5; i++) push(16'hB000 + 16'(i));
        wait_cnt(4'd7);
        check("mid_level5", 32'(level), 32'(5));
        rst = 1'b1;
        #1;
        check("mid_async_level", 32'(level), 32'(0));
        check("mid_async_data", 32'(data), 32'(0));
        check("mid_async_ws", 32'(ws), 32'(1));
        check("mid_async_strobe", 32'(word_start), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        begin
            int n;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!word_start && n < 40);
            check("mid_first_load_delay", 32'(n), 32'(16));
            check("mid_first_data", 32'(data), 32'(0));
            check("mid_first_ws", 32'(ws), 32'(0));
        end

        // Streaming: 200 random samples reassembled through a shifter model.
        @(posedge clk);
        rec_en = 1'b1;
        @(negedge clk);
        clr_underrun = 1'b1;
        for (int i = 0; i < 200; i++) begin
            logic [15:0] v;
            v = 16'($urandom_range(0, 65535));
            sent_q.push_back(v);
            push(v);
            clr_underrun = 1'b0;
        end
        begin
            int g;
            g = 0;
            while (rec_q.size() < 200 && g < 4000) begin
                @(negedge clk);
                g++;
            end
            check("stream_count", 32'(rec_q.size() >= 200), 32'(1));
        end
        for (int i = 0; i < 200; i++) begin
            if (i < rec_q.size()) check("stream_word", 32'(rec_q[i]), 32'(sent_q[i]));
        end
        check("stream_no_underrun", 32'(underrun), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
